// File: rtl/falafel_lsu_v2.sv
// Load/store sequencer for the falafel allocator: expands one core header command
// into single-word memory transactions (lock spin with CAS and backoff, unlock, header load/store).
module falafel_lsu_v2 #(
  parameter int unsigned       DATA_W           = 32,
  parameter int unsigned       ADDR_W           = 32,
  parameter logic [ADDR_W-1:0] NEXT_ADDR_OFFSET = ADDR_W'(4),
  parameter logic [ADDR_W-1:0] LOCK_ADDR        = '0,
  parameter logic [DATA_W-1:0] EMPTY_KEY        = '0,
  parameter logic [DATA_W-1:0] LOCK_ID          = DATA_W'(1),
  parameter int unsigned       MAX_LOCK_RETRIES = 8,
  parameter int unsigned       BACKOFF_CYCLES   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_val_i,
  output logic              core_req_rdy_o,
  input  logic [2:0]        core_req_op_i,
  input  logic [ADDR_W-1:0] core_req_addr_i,
  input  logic [DATA_W-1:0] core_req_size_i,
  input  logic [DATA_W-1:0] core_req_next_addr_i,
  output logic              core_rsp_val_o,
  input  logic              core_rsp_rdy_i,
  output logic [ADDR_W-1:0] core_rsp_addr_o,
  output logic [DATA_W-1:0] core_rsp_size_o,
  output logic [DATA_W-1:0] core_rsp_next_addr_o,
  output logic              core_rsp_err_o,
  output logic              mem_req_val_o,
  input  logic              mem_req_rdy_i,
  output logic              mem_req_is_write_o,
  output logic              mem_req_is_cas_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_data_o,
  output logic [DATA_W-1:0] mem_req_cas_exp_o,
  input  logic              mem_rsp_val_i,
  output logic              mem_rsp_rdy_o,
  input  logic [DATA_W-1:0] mem_rsp_data_i
);

  localparam int RETRY_W = (MAX_LOCK_RETRIES > 1) ? $clog2(MAX_LOCK_RETRIES + 1) : 1;
  localparam int BO_W    = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_LOCK_RETRIES);
  localparam logic [BO_W-1:0]    BO_LAST     = BO_W'((BACKOFF_CYCLES == 0) ? 0 : BACKOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_REQ, S_MEM_WAIT, S_BACKOFF, S_CORE_RSP
  } state_t;

  typedef enum logic [2:0] {
    U_LD_KEY, U_CAS, U_ST_UNLOCK, U_LD_SIZE, U_LD_NEXT, U_ST_SIZE, U_ST_NEXT
  } uop_t;

  // Handshakes: a transfer happens on any rising edge where val and rdy are both high;
  // the sender holds val and its payload unchanged until that edge.

  state_t              r_state, w_state;
  uop_t                r_uop, w_uop;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_size, w_size;
  logic [DATA_W-1:0]   r_next, w_next;
  logic [DATA_W-1:0]   r_rsp_size, w_rsp_size;
  logic [DATA_W-1:0]   r_rsp_next, w_rsp_next;
  logic                r_err, w_err;
  logic [RETRY_W-1:0]  r_retry, w_retry;
  logic [BO_W-1:0]     r_backoff, w_backoff;
  logic [ADDR_W-1:0]   w_next_ptr;
  logic [RETRY_W-1:0]  w_retry_inc;
  logic                w_fail;

  assign w_next_ptr  = r_addr + NEXT_ADDR_OFFSET;
  assign w_retry_inc = r_retry + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_uop      <= U_LD_KEY;
      r_addr     <= '0;
      r_size     <= '0;
      r_next     <= '0;
      r_rsp_size <= '0;
      r_rsp_next <= '0;
      r_err      <= 1'b0;
      r_retry    <= '0;
      r_backoff  <= '0;
    end else begin
      r_state    <= w_state;
      r_uop      <= w_uop;
      r_addr     <= w_addr;
      r_size     <= w_size;
      r_next     <= w_next;
      r_rsp_size <= w_rsp_size;
      r_rsp_next <= w_rsp_next;
      r_err      <= w_err;
      r_retry    <= w_retry;
      r_backoff  <= w_backoff;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_uop      = r_uop;
    w_addr     = r_addr;
    w_size     = r_size;
    w_next     = r_next;
    w_rsp_size = r_rsp_size;
    w_rsp_next = r_rsp_next;
    w_err      = r_err;
    w_retry    = r_retry;
    w_backoff  = r_backoff;
    w_fail     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (core_req_val_i) begin
          w_addr     = core_req_addr_i;
          w_size     = core_req_size_i;
          w_next     = core_req_next_addr_i;
          w_retry    = '0;
          w_backoff  = '0;
          w_err      = 1'b0;
          w_rsp_size = '0;
          w_rsp_next = '0;
          w_state    = S_MEM_REQ;
          case (core_req_op_i)
            3'd0:    w_uop = U_LD_KEY;
            3'd1:    w_uop = U_ST_UNLOCK;
            3'd2:    w_uop = U_LD_SIZE;
            3'd3:    w_uop = U_ST_SIZE;
            3'd4:    w_uop = U_ST_NEXT;
            default: begin
              w_err   = 1'b1;
              w_state = S_CORE_RSP;
            end
          endcase
        end
      end
      S_MEM_REQ: begin
        if (mem_req_rdy_i) w_state = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_rsp_val_i) begin
          w_state = S_MEM_REQ;
          case (r_uop)
            U_LD_KEY: begin
              if (mem_rsp_data_i == EMPTY_KEY) w_uop = U_CAS;
              else                             w_fail = 1'b1;
            end
            U_CAS: begin
              if (mem_rsp_data_i == EMPTY_KEY) w_state = S_CORE_RSP;
              else                             w_fail = 1'b1;
            end
            U_LD_SIZE: begin
              w_rsp_size = mem_rsp_data_i;
              w_uop      = U_LD_NEXT;
            end
            U_LD_NEXT: begin
              w_rsp_next = mem_rsp_data_i;
              w_state    = S_CORE_RSP;
            end
            U_ST_SIZE: w_uop   = U_ST_NEXT;
            default:   w_state = S_CORE_RSP;
          endcase
          // A lost lock race (key held, or CAS beaten) restarts from the key load.
          if (w_fail) begin
            w_retry = w_retry_inc;
            w_uop   = U_LD_KEY;
            if (MAX_LOCK_RETRIES != 0 && w_retry_inc == RETRY_LIMIT) begin
              w_err   = 1'b1;
              w_state = S_CORE_RSP;
            end else if (BACKOFF_CYCLES != 0) begin
              w_backoff = '0;
              w_state   = S_BACKOFF;
            end
          end
        end
      end
      S_BACKOFF: begin
        if (r_backoff == BO_LAST) begin
          w_backoff = '0;
          w_state   = S_MEM_REQ;
        end else begin
          w_backoff = r_backoff + 1'b1;
        end
      end
      S_CORE_RSP: begin
        if (core_rsp_rdy_i) begin
          w_rsp_size = '0;
          w_rsp_next = '0;
          w_state    = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign core_req_rdy_o       = (r_state == S_IDLE);
  assign mem_req_val_o        = (r_state == S_MEM_REQ);
  assign mem_rsp_rdy_o        = (r_state == S_MEM_WAIT);
  assign core_rsp_val_o       = (r_state == S_CORE_RSP);
  assign core_rsp_addr_o      = core_rsp_val_o ? r_addr     : '0;
  assign core_rsp_size_o      = core_rsp_val_o ? r_rsp_size : '0;
  assign core_rsp_next_addr_o = core_rsp_val_o ? r_rsp_next : '0;
  assign core_rsp_err_o       = core_rsp_val_o & r_err;

  always_comb begin
    mem_req_is_write_o = 1'b0;
    mem_req_is_cas_o   = 1'b0;
    mem_req_addr_o     = '0;
    mem_req_data_o     = '0;
    mem_req_cas_exp_o  = '0;
    if (r_state == S_MEM_REQ) begin
      case (r_uop)
        U_LD_KEY: mem_req_addr_o = LOCK_ADDR;
        U_CAS: begin
          mem_req_is_write_o = 1'b1;
          mem_req_is_cas_o   = 1'b1;
          mem_req_addr_o     = LOCK_ADDR;
          mem_req_data_o     = LOCK_ID;
          mem_req_cas_exp_o  = EMPTY_KEY;
        end
        U_ST_UNLOCK: begin
          mem_req_is_write_o = 1'b1;
          mem_req_addr_o     = LOCK_ADDR;
          mem_req_data_o     = EMPTY_KEY;
        end
        U_LD_SIZE: mem_req_addr_o = r_addr;
        U_LD_NEXT: mem_req_addr_o = w_next_ptr;
        U_ST_SIZE: begin
          mem_req_is_write_o = 1'b1;
          mem_req_addr_o     = r_addr;
          mem_req_data_o     = r_size;
        end
        U_ST_NEXT: begin
          mem_req_is_write_o = 1'b1;
          mem_req_addr_o     = w_next_ptr;
          mem_req_data_o     = r_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_falafel_lsu_v2.sv
// Directed bench for falafel_lsu_v2: a word memory responder plus a scoreboard of
// expected core responses, checked with immediate assertions.
module tb_falafel_lsu_v2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        core_req_val_i = 1'b0;
  logic        core_req_rdy_o;
  logic [2:0]  core_req_op_i = '0;
  logic [31:0] core_req_addr_i = '0;
  logic [31:0] core_req_size_i = '0;
  logic [31:0] core_req_next_addr_i = '0;
  logic        core_rsp_val_o;
  logic        core_rsp_rdy_i = 1'b1;
  logic [31:0] core_rsp_addr_o;
  logic [31:0] core_rsp_size_o;
  logic [31:0] core_rsp_next_addr_o;
  logic        core_rsp_err_o;
  logic        mem_req_val_o;
  logic        mem_req_rdy_i = 1'b1;
  logic        mem_req_is_write_o;
  logic        mem_req_is_cas_o;
  logic [31:0] mem_req_addr_o;
  logic [31:0] mem_req_data_o;
  logic [31:0] mem_req_cas_exp_o;
  logic        mem_rsp_val_i = 1'b0;
  logic        mem_rsp_rdy_o;
  logic [31:0] mem_rsp_data_i = '0;

  falafel_lsu_v2 #(
    .MAX_LOCK_RETRIES (3),
    .BACKOFF_CYCLES   (4)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .core_req_val_i       (core_req_val_i),
    .core_req_rdy_o       (core_req_rdy_o),
    .core_req_op_i        (core_req_op_i),
    .core_req_addr_i      (core_req_addr_i),
    .core_req_size_i      (core_req_size_i),
    .core_req_next_addr_i (core_req_next_addr_i),
    .core_rsp_val_o       (core_rsp_val_o),
    .core_rsp_rdy_i       (core_rsp_rdy_i),
    .core_rsp_addr_o      (core_rsp_addr_o),
    .core_rsp_size_o      (core_rsp_size_o),
    .core_rsp_next_addr_o (core_rsp_next_addr_o),
    .core_rsp_err_o       (core_rsp_err_o),
    .mem_req_val_o        (mem_req_val_o),
    .mem_req_rdy_i        (mem_req_rdy_i),
    .mem_req_is_write_o   (mem_req_is_write_o),
    .mem_req_is_cas_o     (mem_req_is_cas_o),
    .mem_req_addr_o       (mem_req_addr_o),
    .mem_req_data_o       (mem_req_data_o),
    .mem_req_cas_exp_o    (mem_req_cas_exp_o),
    .mem_rsp_val_i        (mem_rsp_val_i),
    .mem_rsp_rdy_o        (mem_rsp_rdy_o),
    .mem_rsp_data_i       (mem_rsp_data_i)
  );

  // ---------------- memory responder ----------------
  logic [31:0] mem [logic [31:0]];
  int          key_cyc_q[$];
  logic [31:0] rd_addr_q[$];
  int          n_rd = 0, n_wr = 0, n_cas = 0, n_val_seen = 0;
  int          stall_target = 0, stalls_done = 0;
  int          force_cas_at = 0;
  logic [31:0] force_val = '0;
  logic [31:0] last_cas_addr = '0, last_cas_exp = '0, last_cas_data = '0;
  logic        pend = 1'b0, rsp_hs = 1'b0;
  logic [31:0] pend_data = '0, rsp_old = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  // Requests are taken on the edge after val&rdy is seen here; the response
  // is presented one cycle later and held until the LSU takes it.
  always @(negedge clk) begin
    if (rst_i) begin
      mem_rsp_val_i  = 1'b0;
      mem_rsp_data_i = '0;
      mem_req_rdy_i  = 1'b1;
      pend           = 1'b0;
      rsp_hs         = 1'b0;
    end else begin
      if (rsp_hs) begin
        mem_rsp_val_i  = 1'b0;
        mem_rsp_data_i = '0;
      end
      if (pend) begin
        mem_rsp_val_i  = 1'b1;
        mem_rsp_data_i = pend_data;
        pend           = 1'b0;
      end
      rsp_hs = mem_rsp_val_i && mem_rsp_rdy_o;
      if (mem_req_val_o) n_val_seen++;
      if (mem_req_val_o && stalls_done < stall_target) begin
        mem_req_rdy_i = 1'b0;
        stalls_done++;
      end else begin
        mem_req_rdy_i = 1'b1;
      end
      if (mem_req_val_o && mem_req_rdy_i) begin
        if (mem_req_is_cas_o) begin
          n_cas++;
          last_cas_addr = mem_req_addr_o;
          last_cas_exp  = mem_req_cas_exp_o;
          last_cas_data = mem_req_data_o;
          if (n_cas == force_cas_at) begin
            rsp_old = force_val;
          end else begin
            rsp_old = mem_rd(mem_req_addr_o);
            if (rsp_old == mem_req_cas_exp_o) mem[mem_req_addr_o] = mem_req_data_o;
          end
          pend_data = rsp_old;
        end else if (mem_req_is_write_o) begin
          n_wr++;
          mem[mem_req_addr_o] = mem_req_data_o;
          pend_data = '0;
        end else begin
          n_rd++;
          rd_addr_q.push_back(mem_req_addr_o);
          if (mem_req_addr_o == 32'h0) key_cyc_q.push_back(cyc);
          pend_data = mem_rd(mem_req_addr_o);
        end
        pend = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / checking ----------------
  logic [96:0] exp_q[$];   // {err, addr, size, next_addr}
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {core_req_rdy_o, core_rsp_val_o, core_rsp_err_o, mem_req_val_o,
                          mem_rsp_rdy_o, mem_req_is_write_o, mem_req_is_cas_o}, 7'b1000000);
    check({tag, "_data"}, {core_rsp_addr_o, core_rsp_size_o, core_rsp_next_addr_o,
                           mem_req_addr_o, mem_req_data_o, mem_req_cas_exp_o}, '0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] s,
                        input logic [31:0] n, output int acc);
    int k;
    k = 0;
    while (!core_req_rdy_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    core_req_val_i       = 1'b1;
    core_req_op_i        = op;
    core_req_addr_i      = a;
    core_req_size_i      = s;
    core_req_next_addr_i = n;
    acc = cyc;
    @(negedge clk);
    core_req_val_i = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_cyc, input int hold);
    logic [96:0] e;
    int k;
    k = 0;
    while (!core_rsp_val_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!core_rsp_val_o) begin
      check({tag, "_timeout"}, 1'b0, 1'b1);
      return;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 1'b1, 1'b0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_cyc"}, cyc, exp_cyc);
    check({tag, "_rsp"}, {core_rsp_err_o, core_rsp_addr_o, core_rsp_size_o, core_rsp_next_addr_o}, e);
    if (hold > 0) begin
      core_rsp_rdy_i = 1'b0;
      repeat (hold) @(negedge clk);
      check({tag, "_hold"}, {core_rsp_val_o, core_rsp_err_o, core_rsp_addr_o, core_rsp_size_o,
                             core_rsp_next_addr_o}, {1'b1, e});
      core_rsp_rdy_i = 1'b1;
    end
    @(negedge clk);
    check({tag, "_done"}, {core_rsp_val_o, core_req_rdy_o}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c, b_rd, b_wr, b_cas, b_val, b_key, b_ai;
    mem[32'h0]   = 32'h0;
    mem[32'h100] = 32'h40;
    mem[32'h104] = 32'h200;
    repeat (3) @(negedge clk);
    check_reset("reset");
    #2 rst_i = 1'b0;
    @(negedge clk);

    // LOAD, zero-wait memory, response held two cycles by the core
    b_rd = n_rd; b_wr = n_wr; b_ai = rd_addr_q.size();
    exp_q.push_back({1'b0, 32'h100, 32'h40, 32'h200});
    do_cmd(3'd2, 32'h100, 32'h0, 32'h0, c);
    wait_rsp("load", c + 5, 2);
    check("load_nrd", n_rd - b_rd, 2);
    check("load_nwr", n_wr - b_wr, 0);
    check("load_addr0", rd_addr_q[b_ai], 32'h100);
    check("load_addr1", rd_addr_q[b_ai + 1], 32'h104);

    // EDIT_SIZE_AND_NEXT_ADDR with request stalled three cycles
    b_wr = n_wr;
    stall_target = stall_target + 3;
    exp_q.push_back({1'b0, 32'h80, 32'h0, 32'h0});
    do_cmd(3'd3, 32'h80, 32'h10, 32'h300, c);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("edit_hold%0d", i),
            {mem_req_val_o, mem_req_is_write_o, mem_req_is_cas_o, mem_req_addr_o,
             mem_req_data_o, mem_req_cas_exp_o}, {3'b110, 32'h80, 32'h10, 32'h0});
      @(negedge clk);
    end
    check("edit_released", mem_req_val_o, 1'b0);
    wait_rsp("edit", c + 8, 0);
    check("edit_nwr", n_wr - b_wr, 2);
    check("edit_mem_size", mem_rd(32'h80), 32'h10);
    check("edit_mem_next", mem_rd(32'h84), 32'h300);

    // LOCK on a free lock, then UNLOCK
    mem[32'h0] = 32'h0;
    b_rd = n_rd; b_cas = n_cas;
    exp_q.push_back({1'b0, 32'h500, 32'h0, 32'h0});
    do_cmd(3'd0, 32'h500, 32'h0, 32'h0, c);
    wait_rsp("lock", c + 5, 0);
    check("lock_nrd", n_rd - b_rd, 1);
    check("lock_ncas", n_cas - b_cas, 1);
    check("lock_cas_fields", {last_cas_addr, last_cas_exp, last_cas_data}, {32'h0, 32'h0, 32'h1});
    check("lock_word", mem_rd(32'h0), 32'h1);
    b_wr = n_wr;
    exp_q.push_back({1'b0, 32'h500, 32'h0, 32'h0});
    do_cmd(3'd1, 32'h500, 32'h0, 32'h0, c);
    wait_rsp("unlock", c + 3, 0);
    check("unlock_nwr", n_wr - b_wr, 1);
    check("unlock_word", mem_rd(32'h0), 32'h0);

    // LOCK on a held lock: three spaced key reads, then an error
    mem[32'h0] = 32'h7;
    b_rd = n_rd; b_cas = n_cas; b_key = key_cyc_q.size();
    exp_q.push_back({1'b1, 32'h600, 32'h0, 32'h0});
    do_cmd(3'd0, 32'h600, 32'h0, 32'h0, c);
    wait_rsp("held", c + 15, 0);
    check("held_nrd", n_rd - b_rd, 3);
    check("held_ncas", n_cas - b_cas, 0);
    check("held_first", key_cyc_q[b_key], c + 1);
    check("held_gap1", key_cyc_q[b_key + 1] - key_cyc_q[b_key], 6);
    check("held_gap2", key_cyc_q[b_key + 2] - key_cyc_q[b_key + 1], 6);

    // LOCK that loses a CAS race once, then succeeds
    mem[32'h0] = 32'h0;
    b_rd = n_rd; b_cas = n_cas;
    force_cas_at = n_cas + 1;
    force_val    = 32'h5;
    exp_q.push_back({1'b0, 32'h700, 32'h0, 32'h0});
    do_cmd(3'd0, 32'h700, 32'h0, 32'h0, c);
    wait_rsp("race", c + 13, 0);
    check("race_nrd", n_rd - b_rd, 2);
    check("race_ncas", n_cas - b_cas, 2);
    check("race_word", mem_rd(32'h0), 32'h1);

    // Illegal opcode: immediate error, no memory traffic
    b_val = n_val_seen;
    exp_q.push_back({1'b1, 32'h900, 32'h0, 32'h0});
    do_cmd(3'd6, 32'h900, 32'h0, 32'h0, c);
    wait_rsp("illegal", c + 1, 0);
    check("illegal_nomem", n_val_seen - b_val, 0);

    // Reset during a LOAD's wait for memory, then a clean LOAD
    do_cmd(3'd2, 32'h100, 32'h0, 32'h0, c);
    @(negedge clk);
    check("rst_pre_wait", mem_rsp_rdy_o, 1'b1);
    #2 rst_i = 1'b1;
    #1 check_reset("rst_mid");
    repeat (2) @(negedge clk);
    #2 rst_i = 1'b0;
    @(negedge clk);
    check_reset("rst_after");
    exp_q.push_back({1'b0, 32'h100, 32'h40, 32'h200});
    do_cmd(3'd2, 32'h100, 32'h0, 32'h0, c);
    wait_rsp("load_after_rst", c + 5, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
